// File: rtl/qspi_pkg.sv
// Shared definitions for the QSPI command scheduler: flash opcodes, scheduler states, write-class decode.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
package qspi_pkg;

    // Flash opcodes the scheduler issues itself or must recognise.
    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_PP   = 8'h02;
    localparam logic [7:0] OP_SSE  = 8'h20;
    localparam logic [7:0] OP_SE   = 8'hD8;
    localparam logic [7:0] OP_BE   = 8'hC7;
    localparam logic [7:0] OP_WRSR = 8'h01;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ARB       = 4'd1,
        ST_WREN      = 4'd2,
        ST_WREN_WAIT = 4'd3,
        ST_OP        = 4'd4,
        ST_OP_WAIT   = 4'd5,
        ST_GAP       = 4'd6,
        ST_POLL      = 4'd7,
        ST_POLL_WAIT = 4'd8,
        ST_FINISH    = 4'd9
    } sched_st_e;

    // Opcodes that modify the array/status register: need WREN before and WIP polling after.
    function automatic logic is_write_op(input logic [7:0] cmd);
        return (cmd == OP_PP) || (cmd == OP_SSE) || (cmd == OP_SE) ||
               (cmd == OP_BE) || (cmd == OP_WRSR);
    endfunction

endpackage

// File: rtl/qspi_cmd_sched_if.sv
// Scheduler-to-engine command bus: start pulse with cmd/addr/len, done pulse with last read byte.
// Latency: n/a (wires only).
// Backpressure: none; the scheduler never issues a new start before the previous done.
// Ports: master = scheduler (drives eng_start/cmd/addr/len), slave = engine (drives eng_done/eng_rdata).
interface qspi_cmd_sched_if #(
    parameter int ADDR_W = 24,
    parameter int LEN_W  = 9
) ();
    logic              eng_start;
    logic [7:0]        eng_cmd;
    logic [ADDR_W-1:0] eng_addr;
    logic [LEN_W-1:0]  eng_len;
    logic              eng_done;
    logic [7:0]        eng_rdata;

    modport master (
        output eng_start, eng_cmd, eng_addr, eng_len,
        input  eng_done, eng_rdata
    );

    modport slave (
        input  eng_start, eng_cmd, eng_addr, eng_len,
        output eng_done, eng_rdata
    );
endinterface

// File: rtl/qspi_rr_arb.sv
// Combinational round-robin picker: first requester at or after ptr (wrapping) wins.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller decides when to sample the winner.
// Ports: req (request levels), ptr (highest-priority index) -> win_oh (one-hot), win_idx, win_vld.
module qspi_rr_arb #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win_oh,
    output logic [IDX_W-1:0]   win_idx,
    output logic               win_vld
);
    int pos;

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        win_vld = 1'b0;
        pos     = 0;
        // Scan from the farthest offset back to ptr so the nearest active requester is the last write.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = int'(ptr) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            if (req[pos[IDX_W-1:0]]) begin
                win_oh                  = '0;
                win_oh[pos[IDX_W-1:0]]  = 1'b1;
                win_idx                 = pos[IDX_W-1:0];
                win_vld                 = 1'b1;
            end
        end
    end
endmodule

// File: rtl/qspi_cmd_sched.sv
// Flash command scheduler: round-robin grant, WREN prefix and RDSR/WIP polling for write-class opcodes.
// Latency: req seen in IDLE -> gnt 2 cycles later, first eng_start 3 cycles later; done 2 cycles after final eng_done.
// Backpressure: requesters wait on gnt/done; one engine command in flight, next start only after eng_done.
// Ports: ref_clk/rst_n; per-client req/req_cmd/req_addr/req_len in, gnt/done/err out; eng = engine bus (master).
module qspi_cmd_sched
    import qspi_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int ADDR_W   = 24,
    parameter int LEN_W    = 9,
    parameter int POLL_GAP = 256,
    parameter int POLL_MAX = 65535
) (
    input  logic                      ref_clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*8-1:0]      req_cmd,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic [NUM_REQ-1:0]        err,
    qspi_cmd_sched_if.master          eng
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int GAP_W = $clog2(POLL_GAP + 1);

    // Per-client views of the flattened request buses.
    logic [7:0]        cmd_arr  [NUM_REQ];
    logic [ADDR_W-1:0] addr_arr [NUM_REQ];
    logic [LEN_W-1:0]  len_arr  [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_split
        assign cmd_arr[g]  = req_cmd[g*8 +: 8];
        assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
        assign len_arr[g]  = req_len[g*LEN_W +: LEN_W];
    end

    sched_st_e          st_q, st_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   win_q, win_d;
    logic [7:0]         cmd_q, cmd_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               wr_q, wr_d;
    logic               tmo_q, tmo_d;
    logic [15:0]        poll_cnt_q, poll_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [NUM_REQ-1:0] err_q, err_d;
    logic               eng_start_q, eng_start_d;
    logic [7:0]         eng_cmd_q, eng_cmd_d;
    logic [ADDR_W-1:0]  eng_addr_q, eng_addr_d;
    logic [LEN_W-1:0]   eng_len_q, eng_len_d;

    logic [NUM_REQ-1:0] arb_oh;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_vld;

    // Only WIP (bit 0) of the status byte matters.
    logic rdata_unused;
    assign rdata_unused = ^eng.eng_rdata[7:1];

    qspi_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req     (req),
        .ptr     (ptr_q),
        .win_oh  (arb_oh),
        .win_idx (arb_idx),
        .win_vld (arb_vld)
    );

    always_comb begin
        st_d        = st_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        len_d       = len_q;
        wr_d        = wr_q;
        tmo_d       = tmo_q;
        poll_cnt_d  = poll_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        gnt_d       = gnt_q;
        done_d      = '0;
        err_d       = '0;
        eng_start_d = 1'b0;
        eng_cmd_d   = eng_cmd_q;
        eng_addr_d  = eng_addr_q;
        eng_len_d   = eng_len_q;

        case (st_q)
            ST_IDLE: begin
                if (|req) begin
                    st_d = ST_ARB;
                end
            end
            ST_ARB: begin
                // A request may have dropped since IDLE; fall back rather than grant nobody.
                if (arb_vld) begin
                    win_d      = arb_idx;
                    gnt_d      = arb_oh;
                    cmd_d      = cmd_arr[arb_idx];
                    addr_d     = addr_arr[arb_idx];
                    len_d      = len_arr[arb_idx];
                    wr_d       = is_write_op(cmd_arr[arb_idx]);
                    tmo_d      = 1'b0;
                    poll_cnt_d = '0;
                    st_d       = is_write_op(cmd_arr[arb_idx]) ? ST_WREN : ST_OP;
                end else begin
                    st_d = ST_IDLE;
                end
            end
            ST_WREN: begin
                eng_start_d = 1'b1;
                eng_cmd_d   = OP_WREN;
                eng_addr_d  = '0;
                eng_len_d   = '0;
                st_d        = ST_WREN_WAIT;
            end
            ST_WREN_WAIT: begin
                if (eng.eng_done) begin
                    st_d = ST_OP;
                end
            end
            ST_OP: begin
                eng_start_d = 1'b1;
                eng_cmd_d   = cmd_q;
                eng_addr_d  = addr_q;
                eng_len_d   = len_q;
                st_d        = ST_OP_WAIT;
            end
            ST_OP_WAIT: begin
                if (eng.eng_done) begin
                    gap_cnt_d = '0;
                    st_d      = wr_q ? ST_GAP : ST_FINISH;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_W'(POLL_GAP - 1)) begin
                    st_d = ST_POLL;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            ST_POLL: begin
                eng_start_d = 1'b1;
                eng_cmd_d   = OP_RDSR;
                eng_addr_d  = '0;
                eng_len_d   = LEN_W'(1);
                poll_cnt_d  = poll_cnt_q + 16'd1;
                st_d        = ST_POLL_WAIT;
            end
            ST_POLL_WAIT: begin
                if (eng.eng_done) begin
                    // WIP clear takes precedence: a last poll that reads ready is a success.
                    if (!eng.eng_rdata[0]) begin
                        st_d = ST_FINISH;
                    end else if (poll_cnt_q == 16'(POLL_MAX)) begin
                        tmo_d = 1'b1;
                        st_d  = ST_FINISH;
                    end else begin
                        gap_cnt_d = '0;
                        st_d      = ST_GAP;
                    end
                end
            end
            ST_FINISH: begin
                done_d[win_q] = 1'b1;
                err_d[win_q]  = tmo_q;
                gnt_d         = '0;
                ptr_d         = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
                st_d          = ST_IDLE;
            end
            default: begin
                st_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= ST_IDLE;
            ptr_q       <= '0;
            win_q       <= '0;
            cmd_q       <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            wr_q        <= 1'b0;
            tmo_q       <= 1'b0;
            poll_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            err_q       <= '0;
            eng_start_q <= 1'b0;
            eng_cmd_q   <= '0;
            eng_addr_q  <= '0;
            eng_len_q   <= '0;
        end else begin
            st_q        <= st_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            wr_q        <= wr_d;
            tmo_q       <= tmo_d;
            poll_cnt_q  <= poll_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            eng_start_q <= eng_start_d;
            eng_cmd_q   <= eng_cmd_d;
            eng_addr_q  <= eng_addr_d;
            eng_len_q   <= eng_len_d;
        end
    end

    assign gnt           = gnt_q;
    assign done          = done_q;
    assign err           = err_q;
    assign eng.eng_start = eng_start_q;
    assign eng.eng_cmd   = eng_cmd_q;
    assign eng.eng_addr  = eng_addr_q;
    assign eng.eng_len   = eng_len_q;

endmodule

// File: tb/tb_qspi_cmd_sched.sv
// Directed bench for qspi_cmd_sched: instance A (POLL_MAX=8) covers read, page program, fairness,
// robustness and reset; instance B (POLL_MAX=3) covers the poll timeout. Engine models answer 10 cycles after start.
// Inputs driven at negedge+1; engine models and monitors run at negedge.
module tb_qspi_cmd_sched;
    localparam int ENG_LAT = 10;
    localparam int GAP     = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_n;
    logic [1:0]  req_a, gnt_a, done_a, err_a;
    logic [15:0] cmd_a;
    logic [47:0] addr_a;
    logic [17:0] len_a;
    logic [1:0]  req_b, gnt_b, done_b, err_b;
    logic [15:0] cmd_b;
    logic [47:0] addr_b;
    logic [17:0] len_b;

    qspi_cmd_sched_if #(.ADDR_W(24), .LEN_W(9)) ia ();
    qspi_cmd_sched_if #(.ADDR_W(24), .LEN_W(9)) ib ();

    qspi_cmd_sched #(.NUM_REQ(2), .ADDR_W(24), .LEN_W(9), .POLL_GAP(GAP), .POLL_MAX(8)) dut_a (
        .ref_clk(clk), .rst_n(rst_n), .req(req_a), .req_cmd(cmd_a), .req_addr(addr_a),
        .req_len(len_a), .gnt(gnt_a), .done(done_a), .err(err_a), .eng(ia)
    );

    qspi_cmd_sched #(.NUM_REQ(2), .ADDR_W(24), .LEN_W(9), .POLL_GAP(GAP), .POLL_MAX(3)) dut_b (
        .ref_clk(clk), .rst_n(rst_n), .req(req_b), .req_cmd(cmd_b), .req_addr(addr_b),
        .req_len(len_b), .gnt(gnt_b), .done(done_b), .err(err_b), .eng(ib)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- engine model + monitor, instance A ----------------
    logic [7:0]  sc_q [$];
    logic [23:0] sa_q [$];
    logic [8:0]  sl_q [$];
    int          st_cyc [$];
    int          dn_cyc [$];
    logic [1:0]  gnt_log [$];
    logic [1:0]  gnt_prev = 2'b00;
    int          done_n [2] = '{0, 0};
    int          err_n  [2] = '{0, 0};
    int          last_done_cyc [2] = '{0, 0};
    int          busy_left = 0;
    int          cnt_a = -1;
    bit          inj_a = 1'b0;

    initial begin
        ia.eng_done  = 1'b0;
        ia.eng_rdata = 8'h00;
        forever begin
            @(negedge clk);
            ia.eng_done = 1'b0;
            if (!rst_n) begin
                cnt_a = -1;
            end else if (ia.eng_start) begin
                sc_q.push_back(ia.eng_cmd);
                sa_q.push_back(ia.eng_addr);
                sl_q.push_back(ia.eng_len);
                st_cyc.push_back(cyc);
                cnt_a = ENG_LAT;
                if (ia.eng_cmd == 8'h05) begin
                    ia.eng_rdata = (busy_left > 0) ? 8'h01 : 8'h00;
                    if (busy_left > 0) busy_left--;
                end else begin
                    ia.eng_rdata = 8'h00;
                end
            end else if (cnt_a > 0) begin
                cnt_a--;
                if (cnt_a == 0) begin
                    ia.eng_done = 1'b1;
                    cnt_a = -1;
                    dn_cyc.push_back(cyc);
                end
            end
            if (inj_a && !ia.eng_done) begin
                ia.eng_done = 1'b1;
                inj_a = 1'b0;
            end
            for (int k = 0; k < 2; k++) begin
                if (done_a[k]) begin
                    done_n[k]++;
                    last_done_cyc[k] = cyc;
                end
                if (err_a[k]) err_n[k]++;
            end
            if (gnt_a != 2'b00 && gnt_prev == 2'b00) gnt_log.push_back(gnt_a);
            gnt_prev = gnt_a;
        end
    end

    // ---------------- engine model + monitor, instance B (status stuck busy) ----------------
    int b_st_n = 0, b_rdsr_n = 0, b_both_n = 0, cnt_b = -1;
    int b_done_n [2] = '{0, 0};
    int b_err_n  [2] = '{0, 0};

    initial begin
        ib.eng_done  = 1'b0;
        ib.eng_rdata = 8'h00;
        forever begin
            @(negedge clk);
            ib.eng_done = 1'b0;
            if (!rst_n) begin
                cnt_b = -1;
            end else if (ib.eng_start) begin
                b_st_n++;
                if (ib.eng_cmd == 8'h05) b_rdsr_n++;
                ib.eng_rdata = (ib.eng_cmd == 8'h05) ? 8'h01 : 8'h00;
                cnt_b = ENG_LAT;
            end else if (cnt_b > 0) begin
                cnt_b--;
                if (cnt_b == 0) begin
                    ib.eng_done = 1'b1;
                    cnt_b = -1;
                end
            end
            for (int k = 0; k < 2; k++) begin
                if (done_b[k]) b_done_n[k]++;
                if (err_b[k]) b_err_n[k]++;
                if (done_b[k] && err_b[k]) b_both_n++;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        sc_q.delete(); sa_q.delete(); sl_q.delete();
        st_cyc.delete(); dn_cyc.delete(); gnt_log.delete();
    endtask

    function automatic int ev_val(input int sel);
        case (sel)
            0: return done_n[0];
            1: return done_n[1];
            2: return done_n[0] + done_n[1];
            3: return sc_q.size();
            4: return dn_cyc.size();
            default: return b_done_n[0];
        endcase
    endfunction

    // Bounded wait on a monitored count; an expired budget is reported as a failed comparison.
    task automatic wait_ev(input string tag, input int sel, input int tgt, input int budget);
        int n = 0;
        while (ev_val(sel) < tgt && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(ev_val(sel) >= tgt), 32'd1);
    endtask

    logic [7:0] exp_pp [6] = '{8'h06, 8'h02, 8'h05, 8'h05, 8'h05, 8'h05};
    logic [7:0] exp_rb [4] = '{8'h06, 8'h02, 8'h05, 8'h05};
    logic [1:0] exp_fair [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    int saved0, saved1;

    initial begin
        rst_n = 1'b0;
        req_a = '0; cmd_a = '0; addr_a = '0; len_a = '0;
        req_b = '0; cmd_b = '0; addr_b = '0; len_b = '0;
        repeat (3) tick();
        chk("rst_gnt", 32'(gnt_a), 0);
        chk("rst_done", 32'(done_a), 0);
        chk("rst_err", 32'(err_a), 0);
        chk("rst_start", 32'(ia.eng_start), 0);
        chk("rst_cmd", 32'(ia.eng_cmd), 0);
        chk("rst_addr", 32'(ia.eng_addr), 0);
        chk("rst_len", 32'(ia.eng_len), 0);
        chk("rst_gnt_b", 32'(gnt_b), 0);
        rst_n = 1'b1;
        tick();

        // ---- read on client 0 ----
        clear_logs();
        cmd_a[7:0] = 8'h03; addr_a[23:0] = 24'h000100; len_a[8:0] = 9'd4;
        req_a = 2'b01;
        tick();
        chk("rd_gnt_early", 32'(gnt_a), 0);
        tick();
        chk("rd_gnt", 32'(gnt_a), 32'h1);
        chk("rd_start_early", 32'(ia.eng_start), 0);
        tick();
        chk("rd_start", 32'(ia.eng_start), 1);
        wait_ev("rd_done_wait", 0, 1, 100);
        req_a = 2'b00;
        chk("rd_nstart", sc_q.size(), 1);
        chk("rd_cmd", 32'(sc_q[0]), 32'h03);
        chk("rd_addr", 32'(sa_q[0]), 32'h100);
        chk("rd_len", 32'(sl_q[0]), 4);
        chk("rd_done_lat", last_done_cyc[0] - dn_cyc[0], 2);
        repeat (5) tick();
        chk("rd_done_once", done_n[0], 1);
        chk("rd_err", err_n[0], 0);

        // ---- page program on client 1, 3 busy polls ----
        clear_logs();
        cmd_a[15:8] = 8'h02; addr_a[47:24] = 24'h001000; len_a[17:9] = 9'd256;
        busy_left = 3;
        req_a = 2'b10;
        wait_ev("pp_done_wait", 1, 1, 500);
        req_a = 2'b00;
        chk("pp_nstart", sc_q.size(), 6);
        for (int k = 0; k < 6; k++) chk($sformatf("pp_cmd%0d", k), 32'(sc_q[k]), 32'(exp_pp[k]));
        chk("pp_wren_len", 32'(sl_q[0]), 0);
        chk("pp_op_addr", 32'(sa_q[1]), 32'h1000);
        chk("pp_op_len", 32'(sl_q[1]), 256);
        chk("pp_poll_len", 32'(sl_q[2]), 1);
        chk("pp_wren_to_op", st_cyc[1] - dn_cyc[0], 2);
        for (int k = 2; k < 6; k++) chk($sformatf("pp_gap%0d", k), st_cyc[k] - dn_cyc[k-1], GAP + 2);
        chk("pp_done_lat", last_done_cyc[1] - dn_cyc[5], 2);
        chk("pp_err", err_n[1], 0);

        // ---- fairness: both clients hold reads ----
        clear_logs();
        cmd_a = {8'h0B, 8'h03};
        len_a = {9'd8, 9'd4};
        saved0 = done_n[0] + done_n[1];
        req_a = 2'b11;
        wait_ev("fair_wait", 2, saved0 + 4, 400);
        req_a = 2'b00;
        repeat (5) tick();
        chk("fair_ngnt", gnt_log.size(), 4);
        for (int k = 0; k < 4; k++) chk($sformatf("fair_gnt%0d", k), 32'(gnt_log[k]), 32'(exp_fair[k]));

        // ---- robustness: req dropped in OP_WAIT, spurious eng_done in GAP ----
        clear_logs();
        cmd_a[7:0] = 8'h02; addr_a[23:0] = 24'h000200; len_a[8:0] = 9'd16;
        busy_left = 1;
        saved0 = done_n[0];
        req_a = 2'b01;
        wait_ev("rb_op_wait", 3, 2, 100);
        req_a = 2'b00;
        wait_ev("rb_poll1_wait", 4, 3, 100);
        repeat (3) tick();
        inj_a = 1'b1;
        wait_ev("rb_done_wait", 0, saved0 + 1, 200);
        repeat (30) tick();
        chk("rb_done_once", done_n[0], saved0 + 1);
        chk("rb_nstart", sc_q.size(), 4);
        for (int k = 0; k < 4; k++) chk($sformatf("rb_cmd%0d", k), 32'(sc_q[k]), 32'(exp_rb[k]));
        chk("rb_gap", st_cyc[3] - dn_cyc[2], GAP + 2);
        chk("rb_ngnt", gnt_log.size(), 1);
        chk("rb_err", err_n[0], 0);

        // ---- reset during POLL_WAIT, then arbitration restarts at 0 ----
        clear_logs();
        cmd_a[15:8] = 8'h20;
        busy_left = 1000;
        saved0 = done_n[0];
        saved1 = done_n[1];
        req_a = 2'b10;
        wait_ev("rst_poll_wait", 3, 3, 200);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("arst_gnt", 32'(gnt_a), 0);
        chk("arst_start", 32'(ia.eng_start), 0);
        chk("arst_cmd", 32'(ia.eng_cmd), 0);
        chk("arst_addr", 32'(ia.eng_addr), 0);
        chk("arst_len", 32'(ia.eng_len), 0);
        chk("arst_done", 32'(done_a), 0);
        req_a = 2'b00;
        busy_left = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        clear_logs();
        cmd_a = {8'h03, 8'h03};
        req_a = 2'b11;
        repeat (2) tick();
        chk("arst_regrant", 32'(gnt_a), 32'h1);
        req_a = 2'b00;
        wait_ev("arst_done_wait", 0, saved0 + 1, 100);
        chk("arst_no_done1", done_n[1], saved1);
        chk("arst_nstart", sc_q.size(), 1);

        // ---- timeout on instance B: status stuck busy ----
        cmd_b[7:0] = 8'hD8; addr_b[23:0] = 24'h010000; len_b[8:0] = 9'd0;
        req_b = 2'b01;
        wait_ev("tmo_done_wait", 5, 1, 600);
        req_b = 2'b00;
        repeat (5) tick();
        chk("tmo_rdsr", b_rdsr_n, 3);
        chk("tmo_nstart", b_st_n, 5);
        chk("tmo_err", b_err_n[0], 1);
        chk("tmo_coincident", b_both_n, 1);
        chk("tmo_done1", b_done_n[1] + b_err_n[1], 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/qspi_cmd_sched.md
# qspi_cmd_sched

Command scheduler sitting between several flash clients and the single QSPI engine (`qspi_ctrl_top` datapath). Round-robin arbitration grants one requester at a time and sequences its flash command on the engine. Write-class opcodes are automatically prefixed with WREN (0x06) and followed by RDSR (0x05) polling until WIP clears or a timeout expires.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters (2..4).
- `ADDR_W`, 24: flash address width.
- `LEN_W`, 9: data byte-count width (max 256).
- `POLL_GAP`, 256: `ref_clk` cycles idle between consecutive RDSR polls.
- `POLL_MAX`, 65535: maximum RDSR polls before timeout.

Ports:
- `ref_clk`, in, 1: sole clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `req`, in, NUM_REQ: per-client request level.
- `req_cmd`, in, NUM_REQ*8: opcode per client.
- `req_addr`, in, NUM_REQ*ADDR_W: address per client.
- `req_len`, in, NUM_REQ*LEN_W: byte count per client.
- `gnt`, out, NUM_REQ: one-hot grant, held for the whole transaction.
- `done`, out, NUM_REQ: 1-cycle completion pulse.
- `err`, out, NUM_REQ: 1-cycle timeout pulse, coincident with `done`.
- `eng_start`, out, 1: 1-cycle engine start pulse.
- `eng_cmd`, out, 8: opcode to engine.
- `eng_addr`, out, ADDR_W: address to engine.
- `eng_len`, out, LEN_W: byte count to engine.
- `eng_done`, in, 1: 1-cycle engine completion pulse.
- `eng_rdata`, in, 8: last byte read by engine (status byte for RDSR).

## Operation
- Write-class opcodes: 0x02 PP, 0x20 SSE, 0xD8 SE, 0xC7 BE, 0x01 WRSR. All other opcodes are single-phase.
- States:
  - IDLE: any `req` set → ARB.
  - ARB: pick winner round-robin starting at `ptr`; latch its cmd/addr/len; assert `gnt`. Write-class → WREN, else OP.
  - WREN: pulse `eng_start` with cmd=0x06, len=0 → WREN_WAIT.
  - WREN_WAIT: on `eng_done` → OP.
  - OP: pulse `eng_start` with the latched fields → OP_WAIT.
  - OP_WAIT: on `eng_done`, write-class → GAP, else FINISH.
  - GAP: count POLL_GAP cycles → POLL.
  - POLL: pulse `eng_start` with cmd=0x05, len=1; increment poll count → POLL_WAIT.
  - POLL_WAIT: on `eng_done`:
    - `eng_rdata[0]`=0 → FINISH.
    - poll count = POLL_MAX → FINISH with error.
    - else → GAP.
  - FINISH: pulse `done[i]` (and `err[i]` on timeout); drop `gnt`; `ptr` = winner+1 mod NUM_REQ → IDLE.
- Latched fields are frozen at ARB. Requester input changes mid-transaction are ignored.
- Dropping `req` mid-transaction does not abort; the transaction completes and `done` still pulses.
- `eng_done` outside a *_WAIT state is ignored.
- Poll counter is 16 bits and clears in ARB. Gap counter clears on entering GAP.

## Timing
- Reset values: `gnt`, `done`, `err`, `eng_start` = 0; `eng_cmd`/`eng_addr`/`eng_len` = 0; `ptr` = 0; state IDLE.
- Reset mid-transaction returns to IDLE immediately with no `done`. Re-arbitration restarts from requester 0.
- `req` sampled in IDLE at cycle N. `gnt` high at N+2 (ARB registered). First `eng_start` at N+3.
- `eng_cmd`/`eng_addr`/`eng_len` are valid with `eng_start` and held until the matching `eng_done`.
- Non-write op: `done` pulses 2 cycles after `eng_done` (OP_WAIT→FINISH, registered).
- Back-to-back: FINISH→IDLE→ARB, so a minimum of 2 idle cycles between grants. The requester that just finished has lowest priority.
- Simultaneous requests in IDLE: the lowest index at or after `ptr` wins.

## Structure
- `qspi_pkg`: opcode constants (`OP_WREN`, `OP_RDSR`, `OP_PP`, `OP_SSE`, `OP_SE`, `OP_BE`, `OP_WRSR`), state enum `sched_st_e`, function `is_write_op(cmd)`.
- Sub-module `qspi_rr_arb`: combinational round-robin picker with inputs `req` and `ptr`, outputs one-hot winner and index. The FSM, counters and registered outputs stay in `qspi_cmd_sched`.

## Test plan
- Read: client0 cmd=0x03 addr=0x000100 len=4; engine model returns `eng_done` 10 cycles after start → one `eng_start` with 0x03/0x000100/4; `done[0]` 2 cycles after `eng_done`; `err`=0.
- Page program: client1 cmd=0x02 len=256; engine `eng_rdata`=0x01 for 3 polls, then 0x00 → starts in order 0x06, 0x02, 0x05×4; `POLL_GAP` cycles between polls; `done[1]` after the 4th poll.
- Fairness: both clients hold `req` continuously with read ops → grants alternate 0,1,0,1; never two consecutive grants to the same client.
- Timeout: POLL_MAX=3, status stuck at 0x01 → exactly 3 RDSR starts; `done[0]` and `err[0]` pulse together.
- Reset in POLL_WAIT: deassert `rst_n` → all outputs 0 asynchronously; after release, a fresh request is granted from `ptr`=0.
- Robustness: spurious `eng_done` in GAP and `req` dropped during OP_WAIT → no state change; `done` still pulses once.
